spi_mst: RTL and testbench
==========================

SPI_MST -- requirements
Module: spi_mst

Interface
REQ-001 Parameter SCLK_HDIV, default 4: i_clk cycles per SCLK half-period; legal values are 2..255.
REQ-002 Parameter CSB_GAP_CYC, default 16: minimum i_clk cycles CSB stays high between frames; legal values are 8..1023.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-low (i_clk, i_rst_n).
REQ-004 Port i_clk, input, 1: block clock.
REQ-005 Port i_rst_n, input, 1: synchronous active-low reset.
REQ-006 Port i_req_vld, input, 1: request valid.
REQ-007 Port o_req_rdy, output, 1: request accepted when vld&rdy.
REQ-008 Port i_req_wr, input, 1: 1 = write, 0 = read.
REQ-009 Port i_req_addr, input, REG_AW (7): register address.
REQ-010 Port i_req_wdata, input, REG_DW (8): write data.
REQ-011 Port o_rsp_vld, output, 1: single-cycle response strobe.
REQ-012 Port o_rsp_rdata, output, REG_DW: response data field.
REQ-013 Port o_rsp_err, output, 1: response check failed; valid with o_rsp_vld.
REQ-014 Port o_spi_sclk, output, 1: SPI clock, idle low.
REQ-015 Port o_spi_csb, output, 1: chip select, active low, idle high.
REQ-016 Port o_spi_mosi, output, 1: master out.
REQ-017 Port i_spi_miso, input, 1: slave in.

Function
REQ-018 Frame: 24 bits, MSB first, laid out as {wr, addr[6:0], data[7:0], crc[7:0]}; crc = crc16to8_parallel over the upper 16 bits.
REQ-019 Each accepted request runs two frames:
- Frame A carries the command.
- Frame B is a read of the same address with wdata 0 and a valid CRC; it is harmless and clocks out the slave's response to frame A.
REQ-020 FSM states: IDLE -> FRM_A -> GAP_A -> FRM_B -> GAP_B -> IDLE.
- IDLE: o_req_rdy = 1; acceptance moves to FRM_A on the next cycle.
- GAP_A and GAP_B each last exactly CSB_GAP_CYC cycles with CSB high.
- In all non-IDLE states o_req_rdy = 0.
REQ-021 Frame timing:
- CSB falls on entry to FRM_x, with mosi = bit 23 already driven.
- After SCLK_HDIV cycles SCLK rises; it toggles every SCLK_HDIV cycles for exactly 24 rising edges.
- CSB rises SCLK_HDIV cycles after the 24th falling edge, with SCLK low.
REQ-022 Mosi changes only on the i_clk cycle SCLK falls (bits 22..0) and is stable across every rising edge.
REQ-023 Miso is sampled on the i_clk cycle SCLK rises, with no synchronizer; it is stable for at least SCLK_HDIV-1 cycles. Samples shift MSB first into a 24-bit response register during FRM_B only.
REQ-024 The response frame is decoded as {status, addr[6:0], rdata[7:0], crc[7:0]}; status is 1 for a write ack and 0 for a read ack.
REQ-025 o_rsp_vld pulses exactly once, one cycle after GAP_B ends, aligned with the return to IDLE.
REQ-026 o_rsp_rdata = the received rdata field, held until the next response.
REQ-027 Total latency from acceptance to o_rsp_vld = 2*(24*2*SCLK_HDIV + 2*SCLK_HDIV) + 2*CSB_GAP_CYC + 1 cycles.
REQ-028 i_req_* is captured at acceptance; later changes during the transaction have no effect.
REQ-029 Counters: bit counter 5 bits, 0..23, saturates and does not wrap within a frame; divider counter and gap counter are each 10 bits.

Reset
REQ-030 While i_rst_n = 0 at a rising edge, all state returns to IDLE on that edge, including mid-frame:
- Outputs: o_spi_csb = 1, o_spi_sclk = 0, o_spi_mosi = 0, o_req_rdy = 0, o_rsp_vld = 0, o_rsp_err = 0, o_rsp_rdata = 0.
- o_req_rdy rises one cycle after i_rst_n returns to 1.
REQ-031 A frame truncated by reset is not resumed; no o_rsp_vld is produced for it.

Configuration
REQ-032 Macro SPI_MST_RSP_CHK_EN selects response checking.
- Defined: o_rsp_err = (crc mismatch) | (addr field != request addr) | (status != request wr).
- Undefined: o_rsp_err is tied to 0, and the second CRC instance and the compare logic are absent.

Structure
REQ-033 Shared package contents:
- Frame constants: SPI_FRM_BIT_NUM = 24, CMD / DATA / CRC widths of 8.
- FSM state enum spi_mst_st_e.
- REG_AW and REG_DW come from the existing common parameters.
REQ-034 Sub-module: the existing crc16to8_parallel is instantiated for TX, plus a second instance for the RX check under SPI_MST_RSP_CHK_EN; no new sub-module is created.

Verification
REQ-035 Write: req wr=1, addr 0x12, wdata 0x5A.
- Frame A mosi = 0x92, 0x5A, crc(0x925A).
- Frame B mosi = 0x12, 0x00, crc(0x1200).
- Slave model returns {1, 0x12, 0x5A, crc} -> o_rsp_vld once, o_rsp_err = 0.
REQ-036 Read: req wr=0, addr 0x05; slave returns {0, 0x05, 0xC3, crc} -> o_rsp_rdata = 0xC3, o_rsp_err = 0, latency exactly per REQ-027.
REQ-037 Corrupted response CRC, or addr returned 0x06 for addr 0x05 -> o_rsp_err = 1 with the macro defined, o_rsp_err = 0 without it.
REQ-038 Timing check with SCLK_HDIV = 2 and CSB_GAP_CYC = 8:
- exactly 24 rising edges per CSB-low window;
- mosi stable at every rising edge;
- CSB high for 8 cycles between frames.
REQ-039 Back-to-back: req_vld held high for two requests -> the second is accepted only after o_rsp_vld.
REQ-040 Reset asserted at bit 10 of frame A -> csb = 1, sclk = 0, no o_rsp_vld; the next request completes normally.

Source files
------------

// File: rtl/spi_mst_pkg.sv
// Shared types and constants for the SPI register-access master.
// Optional response checking is selected by SPI_MST_RSP_CHK_EN.
package spi_mst_pkg;

  // Common register-bus widths
  localparam int REG_AW = 7;
  localparam int REG_DW = 8;

  localparam int SPI_FRM_BIT_NUM = 24;
  localparam int SPI_CMD_W       = 8;
  localparam int SPI_DATA_W      = 8;
  localparam int SPI_CRC_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRM_A,
    ST_GAP_A,
    ST_FRM_B,
    ST_GAP_B
  } spi_mst_st_e;

  // Position inside one CSB-low frame window
  typedef enum logic [1:0] {
    PH_LEAD,
    PH_SHIFT,
    PH_HOLD,
    PH_TAIL
  } spi_frm_ph_e;

  function automatic logic [SPI_CMD_W+SPI_DATA_W-1:0] frm_hdr(
    input logic              wr,
    input logic [REG_AW-1:0] addr,
    input logic [REG_DW-1:0] data
  );
    return {wr, addr, data};
  endfunction

endpackage

// File: rtl/crc16to8_parallel.sv
// CRC-8 (poly 0x07, init 0, MSB first) over a 16-bit word, fully combinational.
module crc16to8_parallel (
  input  logic [15:0] data,
  output logic [7:0]  crc
);

  logic [7:0] c;

  always_comb begin
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
  end

  assign crc = c;

endmodule

// File: rtl/spi_mst.sv
// SPI register-access master: one command frame, one read-back frame per request.
// Define SPI_MST_RSP_CHK_EN to enable response CRC/addr/status checking.
module spi_mst
  import spi_mst_pkg::*;
#(
  parameter int SCLK_HDIV   = 4,
  parameter int CSB_GAP_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic              i_req_wr,
  input  logic [REG_AW-1:0] i_req_addr,
  input  logic [REG_DW-1:0] i_req_wdata,
  output logic              o_rsp_vld,
  output logic [REG_DW-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_spi_sclk,
  output logic              o_spi_csb,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso
);

  localparam int          FW       = SPI_FRM_BIT_NUM;
  localparam logic [9:0]  DIV_LAST = 10'(SCLK_HDIV - 1);
  localparam logic [9:0]  GAP_LAST = 10'(CSB_GAP_CYC - 1);
  localparam logic [4:0]  BIT_LAST = 5'(FW - 1);

  spi_mst_st_e st, st_nxt;
  spi_frm_ph_e ph;

  logic [9:0]              div_cnt;
  logic [9:0]              gap_cnt;
  logic [4:0]              bit_cnt;
  logic                    rdy_q, sclk_q, csb_q;
  logic                    rsp_vld_q, rsp_err_q;
  logic [REG_DW-1:0]       rdata_q;
  logic                    wr_q;
  logic [REG_AW-1:0]       addr_q;
  logic [FW-1:0]           tx_sr, rx_sr;
  logic [15:0]             tx_hdr;
  logic [SPI_CRC_W-1:0]    tx_crc;
  logic                    accept, in_frm, in_gap, tick, frm_done, gap_done, load_b;
  logic                    rsp_err_nxt;

  assign accept   = i_req_vld & rdy_q;
  assign in_frm   = (st == ST_FRM_A) || (st == ST_FRM_B);
  assign in_gap   = (st == ST_GAP_A) || (st == ST_GAP_B);
  assign tick     = in_frm && (div_cnt == DIV_LAST);
  assign frm_done = tick && (ph == PH_TAIL);
  assign gap_done = in_gap && (gap_cnt == GAP_LAST);
  assign load_b   = (st == ST_GAP_A) && gap_done;

  // Frame B re-reads the captured address so its response returns frame A's result
  assign tx_hdr = (st == ST_IDLE) ? frm_hdr(i_req_wr, i_req_addr, i_req_wdata)
                                  : frm_hdr(1'b0, addr_q, {REG_DW{1'b0}});

  crc16to8_parallel u_crc_tx (
    .data (tx_hdr),
    .crc  (tx_crc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) st <= ST_IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (accept)   st_nxt = ST_FRM_A;
      ST_FRM_A: if (frm_done) st_nxt = ST_GAP_A;
      ST_GAP_A: if (gap_done) st_nxt = ST_FRM_B;
      ST_FRM_B: if (frm_done) st_nxt = ST_GAP_B;
      ST_GAP_B: if (gap_done) st_nxt = ST_IDLE;
      default:                st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdy_q     <= 1'b0;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      ph        <= PH_LEAD;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rdy_q     <= (st_nxt == ST_IDLE);
      rsp_vld_q <= 1'b0;
      if (accept) begin
        wr_q   <= i_req_wr;
        addr_q <= i_req_addr;
      end
      if (accept || load_b) begin
        tx_sr   <= {tx_hdr, tx_crc};
        csb_q   <= 1'b0;
        sclk_q  <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
        ph      <= PH_LEAD;
      end else if (in_frm) begin
        div_cnt <= tick ? '0 : div_cnt + 10'd1;
        if (tick) begin
          case (ph)
            PH_LEAD, PH_SHIFT: begin
              if (!sclk_q) begin
                sclk_q <= 1'b1;
                ph     <= PH_SHIFT;
                if (st == ST_FRM_B) rx_sr <= {rx_sr[FW-2:0], i_spi_miso};
              end else begin
                sclk_q <= 1'b0;
                if (bit_cnt == BIT_LAST) ph <= PH_HOLD;
                else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  tx_sr   <= {tx_sr[FW-2:0], 1'b0};
                end
              end
            end
            PH_HOLD: begin
              csb_q <= 1'b1;
              ph    <= PH_TAIL;
            end
            default: gap_cnt <= '0;
          endcase
        end
      end else if (in_gap) begin
        gap_cnt <= gap_cnt + 10'd1;
      end
      if ((st == ST_GAP_B) && gap_done) begin
        rsp_vld_q <= 1'b1;
        rdata_q   <= rx_sr[15:8];
        rsp_err_q <= rsp_err_nxt;
      end
    end
  end

`ifdef SPI_MST_RSP_CHK_EN
  logic [SPI_CRC_W-1:0] rx_crc;

  crc16to8_parallel u_crc_rx (
    .data (rx_sr[FW-1:8]),
    .crc  (rx_crc)
  );

  assign rsp_err_nxt = (rx_crc != rx_sr[7:0]) | (rx_sr[22:16] != addr_q) | (rx_sr[23] != wr_q);
`else
  logic chk_unused;
  assign chk_unused  = ^{wr_q, rx_sr[FW-1]};
  assign rsp_err_nxt = 1'b0;
`endif

  assign o_req_rdy   = rdy_q;
  assign o_rsp_vld   = rsp_vld_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_spi_sclk  = sclk_q;
  assign o_spi_csb   = csb_q;
  assign o_spi_mosi  = tx_sr[FW-1];

endmodule

// File: tb/tb_spi_mst.sv
// Bench for spi_mst: vector table, random requests vs. a frame-level model,
// back-to-back and mid-frame reset sequences.
module tb_spi_mst;

  localparam int HDIV = 2;
  localparam int GAP  = 8;
  localparam int LAT  = 2 * (24 * 2 * HDIV + 2 * HDIV) + 2 * GAP + 1;
`ifdef SPI_MST_RSP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_req_vld = 1'b0;
  logic       i_req_wr = 1'b0;
  logic [6:0] i_req_addr = '0;
  logic [7:0] i_req_wdata = '0;
  logic       i_spi_miso = 1'b0;
  logic       o_req_rdy, o_rsp_vld, o_rsp_err, o_spi_sclk, o_spi_csb, o_spi_mosi;
  logic [7:0] o_rsp_rdata;

  logic [23:0] slv_resp = '0;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  spi_mst #(.SCLK_HDIV(HDIV), .CSB_GAP_CYC(GAP)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_vld   (i_req_vld),
    .o_req_rdy   (o_req_rdy),
    .i_req_wr    (i_req_wr),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_vld   (o_rsp_vld),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_spi_sclk  (o_spi_sclk),
    .o_spi_csb   (o_spi_csb),
    .o_spi_mosi  (o_spi_mosi),
    .i_spi_miso  (i_spi_miso)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Slave: bit 23 presented while CSB is high, next bit after each SCLK fall
  int   sidx = 0;
  logic s_sclk_p = 1'b0;
  always @(posedge i_clk) begin
    #1;
    if (o_spi_csb) sidx = 0;
    else if (s_sclk_p && !o_spi_sclk) sidx = sidx + 1;
    s_sclk_p = o_spi_sclk;
    i_spi_miso = (sidx < 24) ? slv_resp[23 - sidx] : 1'b0;
  end

  // CRC as polynomial long division of {d, 8'h00} by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [15:0] d);
    logic [23:0] r;
    r = {d, 8'h00};
    for (int i = 23; i >= 8; i--)
      if (r[i]) r = r ^ (24'h107 << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [23:0] mk_resp(input logic st, input logic [6:0] a,
                                          input logic [7:0] d, input logic [7:0] crc_x);
    return {st, a, d, crc_ref({st, a, d}) ^ crc_x};
  endfunction

  function automatic logic err_ref(input logic wr, input logic [6:0] a, input logic [23:0] r);
    return (crc_ref(r[23:8]) != r[7:0]) || (r[22:16] != a) || (r[23] != wr);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [6:0] addr,
                         input logic [7:0] wdata, input logic [23:0] resp,
                         input logic [7:0] exp_rd, input logic exp_err_chk);
    logic [23:0] cap, exp_a, exp_b;
    logic [23:0] frm [2];
    int          rises [2];
    int          nf, hi, gap_len, nvld, c_acc, c_rsp, stab, wait_n;
    logic        sclk_p, csb_p, mosi_p, er;
    logic [7:0]  rd;
    exp_a = {wr, addr, wdata, crc_ref({wr, addr, wdata})};
    exp_b = {1'b0, addr, 8'h00, crc_ref({1'b0, addr, 8'h00})};
    slv_resp = resp;
    @(negedge i_clk);
    i_req_vld = 1'b1; i_req_wr = wr; i_req_addr = addr; i_req_wdata = wdata;
    wait_n = 0;
    while (!o_req_rdy && wait_n < 300) begin @(negedge i_clk); wait_n++; end
    chk({tag, ".accept"}, 32'(o_req_rdy), 32'd1);
    c_acc = cyc;
    sclk_p = o_spi_sclk; csb_p = o_spi_csb; mosi_p = o_spi_mosi;
    @(negedge i_clk);
    // Request lines change after acceptance and must not matter
    i_req_vld = 1'b0; i_req_wr = ~wr; i_req_addr = ~addr; i_req_wdata = 8'($urandom);
    nf = 0; hi = 0; gap_len = -1; nvld = 0; c_rsp = -1; stab = 0; cap = '0;
    frm[0] = '0; frm[1] = '0; rises[0] = 0; rises[1] = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < LAT + 20; k++) begin
      if (!o_spi_csb) begin
        if (csb_p) begin
          if (nf == 1) gap_len = hi;
          cap = '0;
        end
        if (o_spi_sclk && !sclk_p) begin
          if (nf < 2) rises[nf]++;
          if (o_spi_mosi !== mosi_p) stab++;
          cap = {cap[22:0], o_spi_mosi};
        end
        hi = 0;
      end else begin
        hi++;
        if (!csb_p) begin
          if (nf < 2) frm[nf] = cap;
          nf++;
        end
      end
      if (o_rsp_vld) begin nvld++; c_rsp = cyc; rd = o_rsp_rdata; er = o_rsp_err; end
      sclk_p = o_spi_sclk; csb_p = o_spi_csb; mosi_p = o_spi_mosi;
      @(negedge i_clk);
    end
    chk({tag, ".frames"},   32'(nf),       32'd2);
    chk({tag, ".mosi_a"},   32'(frm[0]),   32'(exp_a));
    chk({tag, ".mosi_b"},   32'(frm[1]),   32'(exp_b));
    chk({tag, ".rises_a"},  32'(rises[0]), 32'd24);
    chk({tag, ".rises_b"},  32'(rises[1]), 32'd24);
    chk({tag, ".mosi_stb"}, 32'(stab),     32'd0);
    chk({tag, ".gap_min"},  32'(gap_len >= GAP), 32'd1);
    chk({tag, ".rsp_cnt"},  32'(nvld),     32'd1);
    chk({tag, ".latency"},  32'(c_rsp - c_acc), 32'(LAT));
    chk({tag, ".rdata"},    32'(rd),       32'(exp_rd));
    chk({tag, ".err"},      32'(er),       32'(CHK & exp_err_chk));
  endtask

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [23:0] resp;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr, er_m;
    logic [6:0]  addr;
    logic [7:0]  wdata, rdata;
    logic [23:0] resp;
    int          c1, c2, c_rsp, n, rises, nvld, lowc;
    logic        sclk_p;

    tv[0] = '{1'b1, 7'h12, 8'h5A, mk_resp(1'b1, 7'h12, 8'h5A, 8'h00), 8'h5A, 1'b0};
    tv[1] = '{1'b0, 7'h05, 8'h00, mk_resp(1'b0, 7'h05, 8'hC3, 8'h00), 8'hC3, 1'b0};
    tv[2] = '{1'b0, 7'h05, 8'h00, mk_resp(1'b0, 7'h05, 8'hC3, 8'h01), 8'hC3, 1'b1};
    tv[3] = '{1'b0, 7'h05, 8'h00, mk_resp(1'b0, 7'h06, 8'hC3, 8'h00), 8'hC3, 1'b1};
    tv[4] = '{1'b1, 7'h7F, 8'hFF, mk_resp(1'b0, 7'h7F, 8'h11, 8'h00), 8'h11, 1'b1};
    tv[5] = '{1'b0, 7'h00, 8'h00, mk_resp(1'b0, 7'h00, 8'h00, 8'h00), 8'h00, 1'b0};

    repeat (3) @(negedge i_clk);
    chk("rst.csb",   32'(o_spi_csb),   32'd1);
    chk("rst.sclk",  32'(o_spi_sclk),  32'd0);
    chk("rst.mosi",  32'(o_spi_mosi),  32'd0);
    chk("rst.rdy",   32'(o_req_rdy),   32'd0);
    chk("rst.vld",   32'(o_rsp_vld),   32'd0);
    chk("rst.rdata", 32'(o_rsp_rdata), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst.rdy_rise", 32'(o_req_rdy), 32'd1);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("tv%0d", i), tv[i].wr, tv[i].addr, tv[i].wdata,
              tv[i].resp, tv[i].exp_rd, tv[i].exp_err);

    for (int i = 0; i < 16; i++) begin
      wr = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom); rdata = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    resp = mk_resp(wr, addr, rdata, 8'h00);
        2:       resp = mk_resp(wr, addr, rdata, 8'($urandom_range(1, 255)));
        default: resp = mk_resp(wr, addr ^ 7'($urandom_range(1, 127)), rdata, 8'h00);
      endcase
      er_m = err_ref(wr, addr, resp);
      run_txn($sformatf("rnd%0d", i), wr, addr, wdata, resp, resp[15:8], er_m);
    end

    // Back-to-back: valid held high across two requests
    slv_resp = mk_resp(1'b1, 7'h21, 8'h3C, 8'h00);
    @(negedge i_clk);
    i_req_vld = 1'b1; i_req_wr = 1'b1; i_req_addr = 7'h21; i_req_wdata = 8'h3C;
    n = 0;
    while (!o_req_rdy && n < 300) begin @(negedge i_clk); n++; end
    c1 = cyc;
    @(negedge i_clk);
    i_req_wdata = 8'h44;
    n = 0; c_rsp = -1; c2 = -1;
    while (n < 400 && c2 < 0) begin
      if (o_rsp_vld && c_rsp < 0) c_rsp = cyc;
      if (o_req_rdy) c2 = cyc;
      else @(negedge i_clk);
      n++;
    end
    chk("b2b.lat1",  32'(c_rsp - c1), 32'(LAT));
    chk("b2b.order", 32'(c_rsp >= 0 && c2 >= c_rsp), 32'd1);
    @(negedge i_clk);
    i_req_vld = 1'b0;
    n = 0; c_rsp = -1;
    while (n < 400 && c_rsp < 0) begin
      if (o_rsp_vld) c_rsp = cyc;
      else @(negedge i_clk);
      n++;
    end
    chk("b2b.lat2",  32'(c_rsp - c2), 32'(LAT));
    chk("b2b.rdata", 32'(o_rsp_rdata), 32'h3C);

    // Reset in the middle of frame A
    slv_resp = mk_resp(1'b1, 7'h33, 8'hA7, 8'h00);
    @(negedge i_clk);
    i_req_vld = 1'b1; i_req_wr = 1'b1; i_req_addr = 7'h33; i_req_wdata = 8'hA7;
    n = 0;
    while (!o_req_rdy && n < 300) begin @(negedge i_clk); n++; end
    @(negedge i_clk);
    i_req_vld = 1'b0;
    rises = 0; sclk_p = o_spi_sclk; n = 0;
    while (rises < 11 && n < 200) begin
      @(negedge i_clk);
      if (o_spi_sclk && !sclk_p) rises++;
      sclk_p = o_spi_sclk; n++;
    end
    chk("mrst.rises", 32'(rises), 32'd11);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mrst.csb",   32'(o_spi_csb),   32'd1);
    chk("mrst.sclk",  32'(o_spi_sclk),  32'd0);
    chk("mrst.mosi",  32'(o_spi_mosi),  32'd0);
    chk("mrst.rdy",   32'(o_req_rdy),   32'd0);
    chk("mrst.vld",   32'(o_rsp_vld),   32'd0);
    chk("mrst.err",   32'(o_rsp_err),   32'd0);
    chk("mrst.rdata", 32'(o_rsp_rdata), 32'd0);
    @(negedge i_clk);
    chk("mrst.rdy_low", 32'(o_req_rdy), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("mrst.rdy_rise", 32'(o_req_rdy), 32'd1);
    nvld = 0; lowc = 0;
    for (int k = 0; k < LAT + 20; k++) begin
      if (o_rsp_vld) nvld++;
      if (!o_spi_csb) lowc++;
      @(negedge i_clk);
    end
    chk("mrst.no_rsp",    32'(nvld), 32'd0);
    chk("mrst.no_resume", 32'(lowc), 32'd0);
    run_txn("post_rst", 1'b0, 7'h05, 8'h00, mk_resp(1'b0, 7'h05, 8'hC3, 8'h00), 8'hC3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
